// File: rtl/boot_io_ctrl_if.sv
// Boot/I-O controller bus bundle.
// Groups the program-load handshake, instruction-memory write port, core
// store port and status/outport signals of boot_io_ctrl.
//   slave  : controller side (boot_io_ctrl)
//   master : environment side (loader, imem, core, observers)
// Build option: LOAD_CHECKSUM_EN adds load_csum (checksum sampled with the
// load_last word).
interface boot_io_ctrl_if #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned NUM_OUTPORTS = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                          load_start;
  logic                          load_valid;
  logic [WIDTH-1:0]              load_data;
  logic                          load_last;
  logic                          load_ready;
`ifdef LOAD_CHECKSUM_EN
  logic [WIDTH-1:0]              load_csum;
`endif
  logic                          imem_wren;
  logic [AW-1:0]                 imem_addr;
  logic [WIDTH-1:0]              imem_wdata;
  logic                          core_run;
  logic                          core_mem_wren;
  logic [WIDTH-1:0]              core_mem_addr;
  logic [WIDTH-1:0]              core_mem_wdata;
  logic [NUM_OUTPORTS*WIDTH-1:0] outport;
  logic [AW:0]                   load_count;
  logic                          load_err;

  modport slave (
`ifdef LOAD_CHECKSUM_EN
    input  load_csum,
`endif
    input  load_start, load_valid, load_data, load_last,
    input  core_mem_wren, core_mem_addr, core_mem_wdata,
    output load_ready, imem_wren, imem_addr, imem_wdata,
    output core_run, outport, load_count, load_err
  );

  modport master (
`ifdef LOAD_CHECKSUM_EN
    output load_csum,
`endif
    output load_start, load_valid, load_data, load_last,
    output core_mem_wren, core_mem_addr, core_mem_wdata,
    input  load_ready, imem_wren, imem_addr, imem_wdata,
    input  core_run, outport, load_count, load_err
  );
endinterface

// File: rtl/boot_io_ctrl.sv
// Boot-and-I/O controller between the external program loader and the core.
// - Valid/ready program-load sequencer writing instruction memory one cycle
//   after each accepted word; holds the core stopped until the load is done.
// - Overflow detection (word offered with memory full) -> sticky error.
// - NUM_OUTPORTS memory-mapped output registers written by core stores while
//   running; outport[i] lives at byte address OUTPORT_BASE + 4*i.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : boot_io_ctrl_if.slave (load handshake, imem write, core store,
//          core_run, outport, load_count, load_err)
// Build option: LOAD_CHECKSUM_EN -- running XOR of accepted words is compared
// against load_csum on the last word; a mismatch ends in the error state.
module boot_io_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      DEPTH        = 256,
  parameter int unsigned      NUM_OUTPORTS = 2,
  parameter logic [WIDTH-1:0] OUTPORT_BASE = 32'hFFFF_FFF0
) (
  input logic           clk,
  input logic           rst,
  boot_io_ctrl_if.slave bus
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_RUN,
    S_ERR
  } state_t;

  state_t                               state_q, state_d;
  logic [CW-1:0]                        count_q, count_d;
  logic                                 err_q, err_d;
  logic                                 wren_q;
  logic [AW-1:0]                        waddr_q;
  logic [WIDTH-1:0]                     wdata_q;
  logic [NUM_OUTPORTS-1:0][WIDTH-1:0]   outport_q;
  logic [NUM_OUTPORTS-1:0]              hit;
  logic                                 ready;
  logic                                 accept;
  logic                                 restart;
  logic                                 csum_ok;
`ifdef LOAD_CHECKSUM_EN
  logic [WIDTH-1:0]                     csum_q, csum_d;
`endif

  // load_start wins over a word offered in the same cycle, so ready drops
  // and the word is neither counted nor written.
  always_comb begin
    ready   = (state_q == S_LOAD) && (count_q < DEPTH_C) && !bus.load_start;
    accept  = ready && bus.load_valid;
    restart = bus.load_start && (state_q != S_DONE);
  end

`ifdef LOAD_CHECKSUM_EN
  // Includes the last word itself, which is being accepted this cycle.
  assign csum_ok = ((csum_q ^ bus.load_data) == bus.load_csum);
`else
  assign csum_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef LOAD_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (restart) begin
      state_d = S_LOAD;
      count_d = '0;
      err_d   = 1'b0;
`ifdef LOAD_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      case (state_q)
        S_LOAD: begin
          if (accept) begin
            count_d = count_q + CW'(1);
`ifdef LOAD_CHECKSUM_EN
            csum_d  = csum_q ^ bus.load_data;
`endif
            if (bus.load_last) begin
              state_d = csum_ok ? S_DONE : S_ERR;
              err_d   = !csum_ok;
            end
          end else if (bus.load_valid && (count_q == DEPTH_C)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_DONE:  state_d = S_RUN;
        S_IDLE,
        S_RUN,
        S_ERR:   state_d = state_q;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      wren_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef LOAD_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      wren_q  <= accept;
      if (accept) begin
        waddr_q <= count_q[AW-1:0];
        wdata_q <= bus.load_data;
      end
`ifdef LOAD_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Exact full-width address match per outport; base + 4*i wraps at WIDTH.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_OUTPORTS; i++) begin
      hit[i] = (state_q == S_RUN) && bus.core_mem_wren &&
               (bus.core_mem_addr[1:0] == 2'b00) &&
               (bus.core_mem_addr == OUTPORT_BASE + WIDTH'(4 * i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outport_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_OUTPORTS; i++) begin
        if (hit[i]) outport_q[i] <= bus.core_mem_wdata;
      end
    end
  end

  assign bus.load_ready = ready;
  assign bus.imem_wren  = wren_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_run   = (state_q == S_RUN);
  assign bus.outport    = outport_q;
  assign bus.load_count = count_q;
  assign bus.load_err   = err_q;

endmodule

// File: tb/tb_boot_io_ctrl.sv
// Self-checking bench for boot_io_ctrl (DEPTH=4 so overflow is reachable).
// Build option: LOAD_CHECKSUM_EN enables the checksum scenarios.
module tb_boot_io_ctrl;
  localparam int unsigned W    = 32;
  localparam int unsigned D    = 4;
  localparam int unsigned NP   = 2;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  boot_io_ctrl_if #(.WIDTH(W), .DEPTH(D), .NUM_OUTPORTS(NP)) bus ();

  boot_io_ctrl #(
    .WIDTH(W), .DEPTH(D), .NUM_OUTPORTS(NP), .OUTPORT_BASE(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] wbuf [8];
  logic [31:0] exp_out [NP];
  bit          run_exp;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP*32-1:0] outport_exp();
    logic [NP*32-1:0] r;
    for (int i = 0; i < NP; i++) r[i*32 +: 32] = exp_out[i];
    return r;
  endfunction

  // Store model: the offset from BASE selects a register if word aligned
  // and within range; anything else (or not running) leaves all registers.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    bus.core_mem_wren  = 1'b1;
    bus.core_mem_addr  = addr;
    bus.core_mem_wdata = data;
    tick;
    bus.core_mem_wren  = 1'b0;
    off = addr - BASE;
    if (run_exp && addr[1:0] == 2'b00 && off < 32'(4 * NP)) exp_out[off[31:2]] = data;
    chk("outport", bus.outport, outport_exp());
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return BASE;
      1:       return BASE + 32'd4;
      2:       return BASE + 32'd8;
      3:       return BASE + 32'd2;
      4:       return BASE + 32'd5;
      default: return $urandom;
    endcase
  endfunction

  // Load wbuf[0..n-1]; n > D exercises overflow.
  task automatic do_load(input int n, input bit last, input bit bad_csum, input bit gaps);
    logic [31:0] x;
    bit          csum_fail;
    x = '0;
    for (int i = 0; i < n; i++) x ^= wbuf[i];
    csum_fail = 1'b0;
`ifdef LOAD_CHECKSUM_EN
    csum_fail = bad_csum;
`endif
    // a word offered alongside load_start must be dropped
    bus.load_start = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = $urandom;
    bus.load_last  = 1'b0;
    chk("run_before_start", bus.core_run, run_exp);
    tick;
    bus.load_start = 1'b0;
    run_exp = 1'b0;
    chk("start_count", bus.load_count, 0);
    chk("start_wren", bus.imem_wren, 0);
    chk("start_err", bus.load_err, 0);
    chk("start_run", bus.core_run, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.load_valid = 1'b0;
        tick;
        chk("gap_wren", bus.imem_wren, 0);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = wbuf[i];
      bus.load_last  = last && (i == n - 1);
`ifdef LOAD_CHECKSUM_EN
      bus.load_csum  = bad_csum ? (x ^ 32'd1) : x;
`endif
      #1;
      if (i < D) begin
        chk("ready", bus.load_ready, 1);
        tick;
        chk("wr_en", bus.imem_wren, 1);
        chk("wr_addr", bus.imem_addr, 64'(i));
        chk("wr_data", bus.imem_wdata, wbuf[i]);
        chk("count", bus.load_count, 64'(i + 1));
      end else begin
        chk("ovf_ready", bus.load_ready, 0);
        tick;
        chk("ovf_err", bus.load_err, 1);
        chk("ovf_run", bus.core_run, 0);
        chk("ovf_wren", bus.imem_wren, 0);
        break;
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    if (n > D) begin
      #1;
      chk("err_ready", bus.load_ready, 0);
      tick;
      chk("err_hold", bus.load_err, 1);
      chk("err_count", bus.load_count, 64'(D));
    end else if (last && csum_fail) begin
      chk("csum_err", bus.load_err, 1);
      chk("csum_run", bus.core_run, 0);
      tick;
      chk("csum_err_hold", bus.load_err, 1);
      chk("csum_wren", bus.imem_wren, 0);
    end else if (last) begin
      chk("done_run", bus.core_run, 0);
      chk("done_ready", bus.load_ready, 0);
      tick;
      run_exp = 1'b1;
      chk("run", bus.core_run, 1);
      chk("run_wren", bus.imem_wren, 0);
      chk("run_err", bus.load_err, 0);
      chk("run_count", bus.load_count, 64'(n));
    end
  endtask

  initial begin
    bus.load_start     = 1'b0;
    bus.load_valid     = 1'b1;
    bus.load_data      = 32'h5A5A_5A5A;
    bus.load_last      = 1'b0;
    bus.core_mem_wren  = 1'b0;
    bus.core_mem_addr  = '0;
    bus.core_mem_wdata = '0;
`ifdef LOAD_CHECKSUM_EN
    bus.load_csum      = '0;
`endif
    run_exp = 1'b0;
    for (int i = 0; i < NP; i++) exp_out[i] = '0;

    repeat (3) begin
      tick;
      chk("rst_ready", bus.load_ready, 0);
      chk("rst_wren", bus.imem_wren, 0);
      chk("rst_run", bus.core_run, 0);
      chk("rst_count", bus.load_count, 0);
      chk("rst_err", bus.load_err, 0);
      chk("rst_outport", bus.outport, 0);
    end
    bus.load_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("idle_ready", bus.load_ready, 0);
    chk("idle_run", bus.core_run, 0);
    do_store(BASE + 32'd4, 32'hCAFE_0001);

    wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    do_load(4, 1'b1, 1'b0, 1'b0);
    do_store(32'hFFFF_FFF4, 32'hDEAD_BEEF);
    do_store(32'hFFFF_FFF5, 32'h1234_5678);
    do_store(BASE, 32'h0BAD_F00D);

    wbuf[0] = 32'h99;
    do_load(1, 1'b1, 1'b0, 1'b0);
    chk("retained", bus.outport, outport_exp());

    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    do_load(5, 1'b0, 1'b0, 1'b0);
    do_store(BASE, 32'h7777_7777);

    repeat (8) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      do_load(n, $urandom_range(0, 3) != 0, 1'b0, 1'b1);
      repeat (3) do_store(pick_addr(), $urandom);
    end

`ifdef LOAD_CHECKSUM_EN
    wbuf[0] = 32'h0F; wbuf[1] = 32'hF0;
    do_load(2, 1'b1, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b1, 1'b0);
`endif

    // asynchronous reset with an imem write in flight
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hABCD_0123;
    bus.load_last  = 1'b0;
    tick;
    bus.load_valid = 1'b0;
    chk("mr_wren_before", bus.imem_wren, 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_wren", bus.imem_wren, 0);
    chk("mr_count", bus.load_count, 0);
    chk("mr_outport", bus.outport, 0);
    chk("mr_ready", bus.load_ready, 0);
    for (int i = 0; i < NP; i++) exp_out[i] = '0;
    run_exp = 1'b0;
    #2 rst = 1'b1;
    tick;
    chk("mr_idle_run", bus.core_run, 0);
    chk("mr_idle_wren", bus.imem_wren, 0);

    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    do_load(3, 1'b1, 1'b0, 1'b1);
    do_store(BASE + 32'd4, 32'h0123_4567);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/boot_io_ctrl.md
Name: boot_io_ctrl

Overview:
Boot-and-I/O controller that sits between the external program-load interface and the rv32i core in the top level. It replaces the old single flash_en/single outport scheme with several pieces:
- a valid/ready program-load sequencer that writes instruction memory and holds the core stopped until loading completes;
- overflow detection;
- NUM_OUTPORTS memory-mapped output registers written by core stores.

Parameters:
WIDTH, 32, data/address width in bits
DEPTH, 256, instruction memory depth in words (power of two, >= 2)
NUM_OUTPORTS, 2, number of memory-mapped output registers (1..8)
OUTPORT_BASE, 32'hFFFF_FFF0, byte address of outport[0]; outport[i] at OUTPORT_BASE + 4*i

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
load_start  input  1  pulse: begin/restart program load
load_valid  input  1  load word present
load_data  input  WIDTH  load word
load_last  input  1  qualifies final word of image (with load_valid)
load_ready  output  1  controller accepts a word this cycle
imem_wren  output  1  instruction memory write enable
imem_addr  output  $clog2(DEPTH)  instruction memory word address
imem_wdata  output  WIDTH  instruction memory write data
core_run  output  1  1 = core may execute; 0 = core held (PC held at 0 by controller)
core_mem_wren  input  1  core store strobe
core_mem_addr  input  WIDTH  core store byte address
core_mem_wdata  input  WIDTH  core store data
outport  output  NUM_OUTPORTS*WIDTH  output registers, outport[i] = bits [i*WIDTH +: WIDTH]
load_count  output  $clog2(DEPTH)+1  words accepted in current/last load
load_err  output  1  sticky load error

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: core_run, load_ready, imem_wren, load_count, load_err, every outport.
- FSM states:
  - IDLE: load_ready=0, core_run=0. load_start -> LOAD next edge, load_count cleared, load_err cleared.
  - LOAD: load_ready=1 while load_count<DEPTH.
    - Accept on load_valid&load_ready at edge k. In cycle k+1, imem_wren=1, imem_addr=load_count value at k, imem_wdata=load_data captured at k. load_count increments at edge k.
    - Back-to-back accepts sustain 1 word/cycle.
    - Accept with load_last -> DONE.
  - LOAD overflow: load_valid=1 with load_count==DEPTH -> ERR. That word is not accepted and load_ready=0 that cycle.
  - DONE: one cycle; load_ready=0; the final imem write occurs in this cycle. -> RUN.
  - RUN: core_run=1. load_start -> LOAD; core_run falls the cycle after load_start is sampled.
  - ERR: load_err=1, core_run=0, load_ready=0. Only load_start leaves (-> LOAD, load_err cleared).
- load_start in LOAD restarts the load: load_count reset to 0, with no write for a word offered that same cycle. load_start takes priority over load_valid.
- imem_wren is 0 in every cycle that does not follow an accept.
- Outports:
  - In RUN only: core_mem_wren=1 and core_mem_addr == OUTPORT_BASE+4*i (full WIDTH compare, low 2 bits must be 0) -> outport[i] <= core_mem_wdata at that edge.
  - Unaligned or non-matching addresses are ignored.
  - Stores outside RUN are ignored.
  - Outport values persist across reloads; only reset clears them.
- Address arithmetic: OUTPORT_BASE+4*i is computed at WIDTH bits, wrapping modulo 2^WIDTH.
- Reset mid-load: everything clears immediately. Any imem write in flight is dropped (imem_wren forced 0).

Optional Feature:
LOAD_CHECKSUM_EN
- Defined:
  - Adds input port load_csum (WIDTH), sampled with the load_last word.
  - The controller keeps a running XOR of all accepted words, including the last.
  - On the last accept, a mismatch between the running XOR and load_csum -> ERR instead of DONE.
  - The accumulator clears on load_start and on reset.
- Undefined: the port is absent and no check is made.

Test Plan:
- Reset: hold rst=0 3 cycles, with load_valid=1 -> all outputs 0, load_ready=0, no imem_wren.
- Load 4 words 0x11,0x22,0x33,0x44 back-to-back, last on 0x44 -> imem writes addr 0..3 in 4 consecutive cycles; load_count=4; core_run=1 two cycles after the last accept.
- DEPTH=4, offer 5 words with no load_last -> 4 writes; then load_err=1, load_ready=0, core_run=0; a subsequent load_start clears load_err.
- RUN, NUM_OUTPORTS=2:
  - store 0xDEADBEEF to 0xFFFFFFF4 -> outport[1]=0xDEADBEEF, outport[0]=0;
  - store to 0xFFFFFFF5 -> no change;
  - store in IDLE -> no change.
- RUN, assert load_start -> core_run=0 next cycle; load 1 word 0x99 with last -> write at addr 0, RUN again; outport values retained.
- LOAD_CHECKSUM_EN: words 0x0F,0xF0, load_csum=0xFF -> RUN; repeat with load_csum=0xFE -> ERR, load_err=1.
